// File: rtl/slr_pkg.sv
// Shared SLR definitions: 576-bit frame layout, payload limit and the state
// encoding used by both the receiver and the transmitter.
package slr_pkg;

  localparam int FRAME_W     = 576;
  localparam int TIME_MSB    = 575;
  localparam int DATA_MSB    = 511;
  localparam int MAX_INS_LEN = 64;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HEAD = 3'd1,
    ST_LEN  = 3'd2,
    ST_TIME = 3'd3,
    ST_DATA = 3'd4,
    ST_SUM  = 3'd5
  } slr_state_e;

  // Payload length actually sent: 0 and anything above the buffer size mean "full buffer".
  function automatic logic [6:0] eff_len(input logic [7:0] cfg_len);
    if (cfg_len == 8'd0 || cfg_len > 8'(MAX_INS_LEN)) begin
      return 7'(MAX_INS_LEN);
    end
    return cfg_len[6:0];
  endfunction

endpackage

// File: rtl/slr_tx_pacer.sv
// Byte pacer for the SLR transmitter. The UART has no busy flag, so every
// strobe request reloads a down-counter and the next slot is granted only when
// it reaches zero. A slot is issued once per request; with no new request the
// pacer goes quiet.
module slr_tx_pacer #(
  parameter int BYTE_GAP = 700
) (
  input  logic clk_sys,
  input  logic rst_n,
  input  logic strobe_req,
  output logic slot
);

  localparam logic [15:0] GAP_LOAD = 16'(BYTE_GAP - 1);

  logic [15:0] gap_cnt_q, gap_cnt_d;
  logic        armed_q, armed_d;

  assign slot = armed_q && (gap_cnt_q == 16'd0);

  // Reload on each strobe, otherwise count down and stop at zero.
  always_comb begin
    gap_cnt_d = gap_cnt_q;
    armed_d   = armed_q;
    if (strobe_req) begin
      gap_cnt_d = GAP_LOAD;
      armed_d   = 1'b1;
    end else begin
      if (gap_cnt_q != 16'd0) begin
        gap_cnt_d = gap_cnt_q - 16'd1;
      end
      if (slot) begin
        armed_d = 1'b0;
      end
    end
  end

  // Counter and slot-armed flag registers.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt_q <= 16'd0;
      armed_q   <= 1'b0;
    end else begin
      gap_cnt_q <= gap_cnt_d;
      armed_q   <= armed_d;
    end
  end

endmodule

// File: rtl/slr_tx_dat.sv
// SLR instruction transmitter: serialises one latched frame as
// header, length, [time], payload, checksum onto the data UART.
// Optional feature macro: SLR_TX_TIME_EN (adds the 8-byte time field).
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | ready for a frame; accept emits the header byte
// HEAD    | header sent, waiting for slot to send the length byte
// LEN     | length sent, next slot sends time byte 0 or data byte 0
// TIME    | sending time bytes 1..7 (SLR_TX_TIME_EN only)
// DATA    | sending payload bytes until index N-1, then the checksum
// SUM     | checksum sent, next slot ends the frame with tx_done
module slr_tx_dat
  import slr_pkg::*;
#(
  parameter int U_DLY    = 1,
  parameter int BYTE_GAP = 700
) (
  input  logic               clk_sys,
  input  logic               rst_n,
  input  logic [7:0]         cfg_ins_length,
  input  logic               cfg_keyer_sel,
  input  logic [7:0]         cfg_pcm_header,
  input  logic [7:0]         cfg_dy_header,
  input  logic [FRAME_W-1:0] txins_data,
  input  logic               txins_data_valid,
  output logic               txins_ready,
  output logic               uart_tx_en,
  output logic [7:0]         uart_tx_data,
  output logic               tx_done
);

  slr_state_e     state_q, state_d;
  logic           txins_ready_q, txins_ready_d;
  logic           uart_tx_en_q, uart_tx_en_d;
  logic [7:0]     uart_tx_data_q, uart_tx_data_d;
  logic           tx_done_q, tx_done_d;
  logic [6:0]     len_q, len_d;
  logic [6:0]     idx_q, idx_d;
  logic [7:0]     sum_q, sum_d;
  logic [DATA_MSB:0] data_q, data_d;
`ifdef SLR_TX_TIME_EN
  logic [63:0]    time_q, time_d;
  logic [2:0]     tidx_q, tidx_d;
`else
  logic           time_unused;
  assign time_unused = ^txins_data[TIME_MSB:DATA_MSB+1];
`endif

  // Register-update delay only matters to behavioural models of this block.
  logic dly_unused;
  assign dly_unused = (U_DLY != 0);

  logic       slot;
  logic       emit;
  logic [7:0] emit_byte;

  slr_tx_pacer #(
    .BYTE_GAP (BYTE_GAP)
  ) u_pacer (
    .clk_sys    (clk_sys),
    .rst_n      (rst_n),
    .strobe_req (emit),
    .slot       (slot)
  );

  assign txins_ready  = txins_ready_q;
  assign uart_tx_en   = uart_tx_en_q;
  assign uart_tx_data = uart_tx_data_q;
  assign tx_done      = tx_done_q;

  // Next-state logic: each slot emits exactly one byte (or ends the frame after SUM).
  always_comb begin
    state_d        = state_q;
    txins_ready_d  = txins_ready_q;
    uart_tx_data_d = uart_tx_data_q;
    len_d          = len_q;
    idx_d          = idx_q;
    sum_d          = sum_q;
    data_d         = data_q;
`ifdef SLR_TX_TIME_EN
    time_d         = time_q;
    tidx_d         = tidx_q;
`endif
    tx_done_d      = 1'b0;
    emit           = 1'b0;
    emit_byte      = uart_tx_data_q;

    case (state_q)
      ST_IDLE: begin
        if (txins_data_valid && txins_ready_q) begin
          data_d        = txins_data[DATA_MSB:0];
`ifdef SLR_TX_TIME_EN
          time_d        = txins_data[TIME_MSB:DATA_MSB+1];
          tidx_d        = 3'd0;
`endif
          len_d         = eff_len(cfg_ins_length);
          idx_d         = 7'd0;
          sum_d         = 8'd0;
          emit          = 1'b1;
          emit_byte     = cfg_keyer_sel ? cfg_dy_header : cfg_pcm_header;
          txins_ready_d = 1'b0;
          state_d       = ST_HEAD;
        end
      end
      ST_HEAD: begin
        if (slot) begin
          emit      = 1'b1;
          emit_byte = {1'b0, len_q};
          sum_d     = {1'b0, len_q};
          state_d   = ST_LEN;
        end
      end
      ST_LEN: begin
        if (slot) begin
          emit = 1'b1;
`ifdef SLR_TX_TIME_EN
          emit_byte = time_q[63:56];
          sum_d     = sum_q + time_q[63:56];
          time_d    = {time_q[55:0], 8'h00};
          tidx_d    = 3'd0;
          state_d   = ST_TIME;
`else
          emit_byte = data_q[DATA_MSB -: 8];
          sum_d     = sum_q + data_q[DATA_MSB -: 8];
          data_d    = {data_q[DATA_MSB-8:0], 8'h00};
          idx_d     = 7'd0;
          state_d   = ST_DATA;
`endif
        end
      end
`ifdef SLR_TX_TIME_EN
      ST_TIME: begin
        if (slot) begin
          emit = 1'b1;
          if (tidx_q == 3'd7) begin
            emit_byte = data_q[DATA_MSB -: 8];
            sum_d     = sum_q + data_q[DATA_MSB -: 8];
            data_d    = {data_q[DATA_MSB-8:0], 8'h00};
            idx_d     = 7'd0;
            state_d   = ST_DATA;
          end else begin
            emit_byte = time_q[63:56];
            sum_d     = sum_q + time_q[63:56];
            time_d    = {time_q[55:0], 8'h00};
            tidx_d    = tidx_q + 3'd1;
          end
        end
      end
`endif
      ST_DATA: begin
        if (slot) begin
          emit = 1'b1;
          if (idx_q == len_q - 7'd1) begin
            emit_byte = sum_q;
            state_d   = ST_SUM;
          end else begin
            emit_byte = data_q[DATA_MSB -: 8];
            sum_d     = sum_q + data_q[DATA_MSB -: 8];
            data_d    = {data_q[DATA_MSB-8:0], 8'h00};
            idx_d     = idx_q + 7'd1;
          end
        end
      end
      ST_SUM: begin
        if (slot) begin
          tx_done_d     = 1'b1;
          txins_ready_d = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      default: begin
        txins_ready_d = 1'b1;
        state_d       = ST_IDLE;
      end
    endcase

    uart_tx_en_d = emit;
    if (emit) begin
      uart_tx_data_d = emit_byte;
    end
  end

  // State, frame buffer and registered outputs.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      txins_ready_q  <= 1'b1;
      uart_tx_en_q   <= 1'b0;
      uart_tx_data_q <= 8'd0;
      tx_done_q      <= 1'b0;
      len_q          <= 7'd0;
      idx_q          <= 7'd0;
      sum_q          <= 8'd0;
      data_q         <= '0;
`ifdef SLR_TX_TIME_EN
      time_q         <= 64'd0;
      tidx_q         <= 3'd0;
`endif
    end else begin
      state_q        <= state_d;
      txins_ready_q  <= txins_ready_d;
      uart_tx_en_q   <= uart_tx_en_d;
      uart_tx_data_q <= uart_tx_data_d;
      tx_done_q      <= tx_done_d;
      len_q          <= len_d;
      idx_q          <= idx_d;
      sum_q          <= sum_d;
      data_q         <= data_d;
`ifdef SLR_TX_TIME_EN
      time_q         <= time_d;
      tidx_q         <= tidx_d;
`endif
    end
  end

endmodule
